// File: rtl/ysyx_22040895_div.sv
// ysyx_22040895_div: iterative radix-2 restoring divider for the RV64M
// div/divu/rem/remu and their W variants. Quotient and remainder are both
// returned. The caller picks which one to write back.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush_i           abandon any operation in progress (outputs keep last value)
//   div_valid_i/ready request handshake; operands and mode latched on accept
//   div_signed_i      1 = signed (div/rem)
//   div_word_i        1 = 32-bit W variant (results sign-extended to 64)
//   dividend_i        rs1
//   divisor_i         rs2
//   out_valid_o/ready result handshake
//   quotient_o        final quotient
//   remainder_o       final remainder
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request, div_ready_o=1
// BUSY  | one restoring step per cycle, r_cnt counts down to 1
// DONE  | result registered, out_valid_o=1 until taken

module ysyx_22040895_div #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            div_valid_i,
  output logic            div_ready_o,
  input  logic            div_signed_i,
  input  logic            div_word_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int HALF = XLEN / 2;
  localparam logic [CNT_W-1:0] N_FULL = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] N_WORD = CNT_W'(HALF);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rem;     // partial remainder
  logic [XLEN-1:0]  r_quo;     // dividend bits shift out of the top, quotient bits in at the bottom
  logic [XLEN-1:0]  r_dvs;     // divisor magnitude
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_word;
  logic [XLEN-1:0]  r_q_out;
  logic [XLEN-1:0]  r_r_out;

  // operand preparation, evaluated in the accept cycle
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_sx, w_a_abs, w_b_abs, w_min;
  logic            w_a_neg, w_b_neg, w_div_zero, w_ovf, w_special;

  always_comb begin
    w_a_ext = div_word_i ? {{HALF{div_signed_i & dividend_i[HALF-1]}}, dividend_i[HALF-1:0]}
                         : dividend_i;
    w_b_ext = div_word_i ? {{HALF{div_signed_i & divisor_i[HALF-1]}}, divisor_i[HALF-1:0]}
                         : divisor_i;
    // W results are always sign-extended, even for divuw/remuw
    w_a_sx  = div_word_i ? {{HALF{dividend_i[HALF-1]}}, dividend_i[HALF-1:0]} : dividend_i;
    w_a_neg = div_signed_i & w_a_ext[XLEN-1];
    w_b_neg = div_signed_i & w_b_ext[XLEN-1];
    w_a_abs = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_abs = w_b_neg ? -w_b_ext : w_b_ext;
    w_min   = div_word_i ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    w_div_zero = (w_b_ext == '0);
    w_ovf      = div_signed_i & (w_a_ext == w_min) & (w_b_ext == '1);
    w_special  = w_div_zero | w_ovf;
  end

  // one restoring step; the shifted remainder is XLEN+1 bits wide
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_q_c, w_r_c, w_q_fin, w_r_fin;

  always_comb begin
    w_shift   = {r_rem, r_quo[XLEN-1]};
    w_ge      = (w_shift >= {1'b0, r_dvs});
    // when w_ge the difference is below the divisor, so XLEN bits suffice
    w_rem_nxt = w_ge ? (w_shift[XLEN-1:0] - r_dvs) : w_shift[XLEN-1:0];
    w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
    w_q_c     = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    w_r_c     = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    w_q_fin   = r_word ? {{HALF{w_q_c[HALF-1]}}, w_q_c[HALF-1:0]} : w_q_c;
    w_r_fin   = r_word ? {{HALF{w_r_c[HALF-1]}}, w_r_c[HALF-1:0]} : w_r_c;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (div_valid_i) w_state_nxt = w_special ? S_DONE : S_BUSY;
      S_BUSY:  if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i) w_state_nxt = S_IDLE;
  end

  // outputs depend on state only
  always_comb begin
    div_ready_o = (r_state == S_IDLE);
    out_valid_o = (r_state == S_DONE);
  end

  // datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_word  <= 1'b0;
      r_q_out <= '0;
      r_r_out <= '0;
    end else if (!flush_i) begin
      if (r_state == S_IDLE && div_valid_i) begin
        if (w_div_zero) begin
          r_q_out <= '1;
          r_r_out <= w_a_sx;
        end else if (w_ovf) begin
          r_q_out <= w_a_sx;
          r_r_out <= '0;
        end else begin
          r_cnt   <= div_word_i ? N_WORD : N_FULL;
          r_rem   <= '0;
          // W ops: place the 32-bit magnitude at the top so its MSB shifts out first
          r_quo   <= div_word_i ? {w_a_abs[HALF-1:0], {HALF{1'b0}}} : w_a_abs;
          r_dvs   <= w_b_abs;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_word  <= div_word_i;
        end
      end else if (r_state == S_BUSY) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_q_out <= w_q_fin;
          r_r_out <= w_r_fin;
        end
      end
    end
  end

  assign quotient_o  = r_q_out;
  assign remainder_o = r_r_out;

endmodule

// File: tb/tb_ysyx_22040895_div.sv
// Self-checking bench for ysyx_22040895_div: a reference model pushes the
// expected quotient/remainder/latency to a scoreboard queue at request time,
// and the entry is popped when the DUT raises out_valid_o.

module tb_ysyx_22040895_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        div_valid_i = 1'b0;
  logic        div_ready_o;
  logic        div_signed_i = 1'b0;
  logic        div_word_i = 1'b0;
  logic [63:0] dividend_i = '0;
  logic [63:0] divisor_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [63:0] quotient_o;
  logic [63:0] remainder_o;

  ysyx_22040895_div #(.XLEN(64), .CNT_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .div_valid_i  (div_valid_i),
    .div_ready_o  (div_ready_o),
    .div_signed_i (div_signed_i),
    .div_word_i   (div_word_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] last_q = '0;
  logic [63:0] last_r = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit s, input bit w, input logic [63:0] a, input logic [63:0] b);
    exp_t               e;
    logic        [31:0] a32, b32, q32, r32;
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa, sbv;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      sa32 = a32;
      sb32 = b32;
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32; e.lat = 1;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = '0; e.lat = 1;
      end else if (s) begin
        q32 = sa32 / sb32; r32 = sa32 % sb32; e.lat = 33;
      end else begin
        q32 = a32 / b32; r32 = a32 % b32; e.lat = 33;
      end
      e.q = {{32{q32[31]}}, q32};
      e.r = {{32{r32[31]}}, r32};
    end else begin
      sa  = a;
      sbv = b;
      if (b == 64'd0) begin
        e.q = '1; e.r = a; e.lat = 1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        e.q = a; e.r = '0; e.lat = 1;
      end else if (s) begin
        e.q = sa / sbv; e.r = sa % sbv; e.lat = 65;
      end else begin
        e.q = a / b; e.r = a % b; e.lat = 65;
      end
    end
    return e;
  endfunction

  // issue one request, wait for the result, check it, optionally stall, then take it
  task automatic do_op(input bit s, input bit w, input logic [63:0] a, input logic [63:0] b,
                       input int hold);
    exp_t e;
    int   edges;
    sb.push_back(model(s, w, a, b));
    div_signed_i = s;
    div_word_i   = w;
    dividend_i   = a;
    divisor_i    = b;
    div_valid_i  = 1'b1;
    @(posedge clk); #1;
    div_valid_i = 1'b0;
    dividend_i  = $urandom;
    divisor_i   = $urandom;
    edges = 1;
    if (sb[0].lat > 1) chk("busy_ready", div_ready_o, 1'b0);
    while (!out_valid_o && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    e = sb.pop_front();
    chk("latency", edges, e.lat);
    chk("quotient", quotient_o, e.q);
    chk("remainder", remainder_o, e.r);
    last_q = e.q;
    last_r = e.r;
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      chk("hold_valid", out_valid_o, 1'b1);
      chk("hold_quotient", quotient_o, e.q);
      chk("hold_remainder", remainder_o, e.r);
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    chk("handoff_valid", out_valid_o, 1'b0);
    chk("handoff_ready", div_ready_o, 1'b1);
  endtask

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", div_ready_o, 1'b1);
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_q", quotient_o, 64'd0);
    chk("rst_r", remainder_o, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(0, 0, 64'd100, 64'd7, 0);
    do_op(1, 0, -64'sd100, 64'd7, 0);
    do_op(1, 0, -64'sd100, -64'sd7, 0);
    do_op(1, 0, 64'h1234, 64'd0, 0);
    do_op(0, 0, 64'h1234, 64'd0, 0);
    do_op(0, 1, 64'hABCD_0000_8000_1234, 64'h1_0000_0000, 0);
    do_op(1, 0, 64'h8000_0000_0000_0000, '1, 0);
    do_op(1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
    do_op(0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 0);
    do_op(0, 0, 64'd1000, 64'd3, 10);

    for (int i = 0; i < 16; i++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = {$urandom, $urandom};
        1:       b = 64'($urandom_range(1, 1000));
        2:       b = -64'($urandom_range(1, 1000));
        default: b = {32'd0, $urandom};
      endcase
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3));
    end

    // flush at BUSY cycle 20 together with a new request
    div_signed_i = 1'b0; div_word_i = 1'b0;
    dividend_i = 64'd12345; divisor_i = 64'd3; div_valid_i = 1'b1;
    @(posedge clk); #1;
    div_valid_i = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    chk("pre_flush_busy", div_ready_o, 1'b0);
    flush_i = 1'b1; div_valid_i = 1'b1;
    dividend_i = 64'd50; divisor_i = 64'd5;
    @(posedge clk); #1;
    flush_i = 1'b0; div_valid_i = 1'b0;
    chk("flush_ready", div_ready_o, 1'b1);
    chk("flush_valid", out_valid_o, 1'b0);
    chk("flush_keep_q", quotient_o, last_q);
    chk("flush_keep_r", remainder_o, last_r);
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid_o || !div_ready_o) seen = 1'b1;
    end
    chk("flush_no_activity", seen, 1'b0);

    // reset mid-BUSY
    dividend_i = 64'd999; divisor_i = 64'd4; div_valid_i = 1'b1;
    @(posedge clk); #1;
    div_valid_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", div_ready_o, 1'b1);
    chk("midrst_valid", out_valid_o, 1'b0);
    chk("midrst_q", quotient_o, 64'd0);
    chk("midrst_r", remainder_o, 64'd0);

    do_op(1, 1, 64'h0000_0000_FFFF_FF9C, 64'd7, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
